// File: rtl/byte_ram_responder.sv
// Byte-wide RAM responder with a memory-mapped transmit path at IoAddr/IoStatAddr.
// Define IO_TX_FIFO_EN for a multi-entry transmit FIFO; otherwise a single holding register is used.
module byte_ram_responder #(
  parameter int unsigned AddrWidth    = 17,
  parameter logic [31:0] IoAddr       = 32'h0003_0000,
  parameter logic [31:0] IoStatAddr   = 32'h0003_0004,
  parameter int unsigned FifoDepthLog = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_from_fc,
  input  logic        is_store_from_fc,
  input  logic [7:0]  data_from_fc,
  output logic [7:0]  data_to_fc,
  output logic        io_full_to_fc,
  output logic [7:0]  io_byte_out,
  output logic        io_valid_out,
  input  logic        io_ready_in,
  output logic        io_overflow_out
);

  localparam int unsigned RamWords = 1 << AddrWidth;

  logic [7:0] mem_r [RamWords];
  logic [7:0] data_r;
  logic [7:0] rd_data_s;
  logic       ram_hit_s;
  logic       io_data_hit_s;
  logic       io_stat_hit_s;
  logic       ram_store_s;
  logic       io_store_s;
  logic       pop_s;
  logic       push_s;
  logic       empty_s;
  logic       full_r;
  logic       ovf_r;

  // RAM decode wins over IO so a low IoAddr can never shadow array bytes.
  assign ram_hit_s     = (addr_from_fc[31:AddrWidth] == '0);
  assign io_data_hit_s = !ram_hit_s && (addr_from_fc == IoAddr);
  assign io_stat_hit_s = !ram_hit_s && (addr_from_fc == IoStatAddr);
  assign ram_store_s   = ram_hit_s && is_store_from_fc;
  assign io_store_s    = io_data_hit_s && is_store_from_fc;
  assign pop_s         = io_valid_out && io_ready_in;

  // Next read byte: write-first on RAM stores, live status on IoStatAddr, zero elsewhere.
  always_comb begin
    rd_data_s = 8'h00;
    if (ram_hit_s) begin
      if (is_store_from_fc) begin
        rd_data_s = data_from_fc;
      end else begin
        rd_data_s = mem_r[addr_from_fc[AddrWidth-1:0]];
      end
    end else if (io_stat_hit_s) begin
      rd_data_s = {5'b0_0000, ovf_r, empty_s, full_r};
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // Registered read-data return.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_r <= 8'h00;
    end else begin
      data_r <= rd_data_s;
    end
  end

  // RAM array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && ram_store_s) begin
      mem_r[addr_from_fc[AddrWidth-1:0]] <= data_from_fc;
    end
  end

`ifdef IO_TX_FIFO_EN
  localparam int unsigned Depth = 1 << FifoDepthLog;
  localparam int unsigned CntW  = FifoDepthLog + 1;
  localparam logic [CntW-1:0]         DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0]         CntOne   = CntW'(1'b1);
  localparam logic [FifoDepthLog-1:0] PtrOne   = FifoDepthLog'(1'b1);

  logic [7:0]              fifo_mem_r [Depth];
  logic [FifoDepthLog-1:0] wr_ptr_r;
  logic [FifoDepthLog-1:0] rd_ptr_r;
  logic [CntW-1:0]         count_r;
  logic [CntW-1:0]         count_nxt_s;

  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
  always_comb begin
    push_s      = io_store_s && (!full_r || pop_s);
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CntOne;
    end else if (!push_s && pop_s) begin
      count_nxt_s = count_r - CntOne;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // FIFO pointers, occupancy, full and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PtrOne;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrOne;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DepthCnt);
      if (io_store_s && !push_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // FIFO storage; not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      fifo_mem_r[wr_ptr_r] <= data_from_fc;
    end
  end

  assign empty_s     = (count_r == '0);
  assign io_byte_out = fifo_mem_r[rd_ptr_r];
`else
  logic [7:0] hold_r;

  // Single slot: full means occupied; push with pop replaces the held byte.
  always_comb begin
    push_s = io_store_s && (!full_r || pop_s);
  end

  // Holding-register occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      if (push_s) begin
        full_r <= 1'b1;
      end else if (pop_s) begin
        full_r <= 1'b0;
      end
      if (io_store_s && !push_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Held byte storage; not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      hold_r <= data_from_fc;
    end
  end

  assign empty_s     = !full_r;
  assign io_byte_out = hold_r;
`endif

  assign data_to_fc      = data_r;
  assign io_full_to_fc   = full_r;
  assign io_valid_out    = !empty_s;
  assign io_overflow_out = ovf_r;

endmodule

// File: tb/tb_byte_ram_responder.sv
// Randomized self-checking bench for byte_ram_responder against a queue/array reference model.
// Tracks IO_TX_FIFO_EN to size the reference transmit queue.
module tb_byte_ram_responder;

  localparam logic [31:0] IO_ADDR   = 32'h0003_0000;
  localparam logic [31:0] STAT_ADDR = 32'h0003_0004;
  localparam logic [31:0] UNMAPPED  = 32'h0004_0000;
`ifdef IO_TX_FIFO_EN
  localparam int TX_DEPTH = 8;
`else
  localparam int TX_DEPTH = 1;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] addr_from_fc;
  logic        is_store_from_fc;
  logic [7:0]  data_from_fc;
  logic [7:0]  data_to_fc;
  logic        io_full_to_fc;
  logic [7:0]  io_byte_out;
  logic        io_valid_out;
  logic        io_ready_in;
  logic        io_overflow_out;

  int n_checks;
  int n_pass;

  logic [7:0] ram_model [int];
  logic [7:0] tx_q [$];
  bit         ovf_model;

  byte_ram_responder dut (
    .clk              (clk),
    .rst              (rst),
    .addr_from_fc     (addr_from_fc),
    .is_store_from_fc (is_store_from_fc),
    .data_from_fc     (data_from_fc),
    .data_to_fc       (data_to_fc),
    .io_full_to_fc    (io_full_to_fc),
    .io_byte_out      (io_byte_out),
    .io_valid_out     (io_valid_out),
    .io_ready_in      (io_ready_in),
    .io_overflow_out  (io_overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_io_state();
    check_eq("io_valid", {31'd0, io_valid_out}, {31'd0, tx_q.size() != 0});
    check_eq("io_full", {31'd0, io_full_to_fc}, {31'd0, tx_q.size() == TX_DEPTH});
    check_eq("io_overflow", {31'd0, io_overflow_out}, {31'd0, ovf_model});
    if (tx_q.size() != 0) begin
      check_eq("io_byte", {24'd0, io_byte_out}, {24'd0, tx_q[0]});
    end
  endtask

  // One clock cycle: drive inputs, advance the model by the spec rules, then compare.
  task automatic cycle(input logic [31:0] a, input bit st, input logic [7:0] d,
                       input bit rdy, input bit rs);
    logic [7:0] exp_d;
    bit         known;
    bit         do_pop;
    bit         do_push;
    int         idx;
    addr_from_fc     = a;
    is_store_from_fc = st;
    data_from_fc     = d;
    io_ready_in      = rdy;
    rst              = rs;
    exp_d = 8'h00;
    known = 1'b1;
    idx   = int'(a[16:0]);
    if (!rs) begin
      exp_d = 8'h00;
    end else if (a[31:17] == 15'd0) begin
      if (st) begin
        exp_d = d;
      end else if (ram_model.exists(idx)) begin
        exp_d = ram_model[idx];
      end else begin
        known = 1'b0;
      end
    end else if (a == STAT_ADDR && !st) begin
      exp_d = {5'd0, ovf_model, tx_q.size() == 0, tx_q.size() == TX_DEPTH};
    end else begin
      exp_d = 8'h00;
      known = !st;
    end
    if (!rs) begin
      tx_q.delete();
      ovf_model = 1'b0;
    end else begin
      do_pop  = (tx_q.size() != 0) && rdy;
      do_push = 1'b0;
      if (st && a == IO_ADDR) begin
        if (tx_q.size() < TX_DEPTH || do_pop) begin
          do_push = 1'b1;
        end else begin
          ovf_model = 1'b1;
        end
      end
      if (do_pop) begin
        void'(tx_q.pop_front());
      end
      if (do_push) begin
        tx_q.push_back(d);
      end
      if (st && a[31:17] == 15'd0) begin
        ram_model[idx] = d;
      end
    end
    @(posedge clk);
    #1;
    if (known) begin
      check_eq("rdata", {24'd0, data_to_fc}, {24'd0, exp_d});
    end
    check_io_state();
  endtask

  function automatic logic [31:0] pick_addr();
    int sel;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0, 1, 2, 3: pick_addr = {26'd0, 6'($urandom_range(0, 63))};
      4:          pick_addr = 32'h0001_FFFF;
      5, 6:       pick_addr = IO_ADDR;
      7:          pick_addr = STAT_ADDR;
      8:          pick_addr = 32'h0002_0000 + 32'($urandom_range(0, 255));
      default:    pick_addr = IO_ADDR + 32'd1;
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    ovf_model = 1'b0;
    rst = 1'b0;
    addr_from_fc = 32'd0;
    is_store_from_fc = 1'b0;
    data_from_fc = 8'h00;
    io_ready_in = 1'b0;
    @(negedge clk);
    cycle(32'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(32'd0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Basic RAM store/read and write-first return.
    cycle(32'h0000_1234, 1'b1, 8'hA5, 1'b0, 1'b1);
    cycle(32'h0000_1234, 1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("ram_readback", {24'd0, data_to_fc}, 32'h0000_00A5);
    cycle(32'h0000_0010, 1'b1, 8'h3C, 1'b0, 1'b1);
    check_eq("write_first", {24'd0, data_to_fc}, 32'h0000_003C);

    // Fill the transmit path, overflow it, read status, then drain.
    for (int i = 0; i < 8; i++) begin
      cycle(IO_ADDR, 1'b1, 8'(8'h41 + i), 1'b0, 1'b1);
    end
    check_eq("full_after_fill", {31'd0, io_full_to_fc}, 32'd1);
    cycle(IO_ADDR, 1'b1, 8'h49, 1'b0, 1'b1);
    check_eq("overflow_set", {31'd0, io_overflow_out}, 32'd1);
    cycle(STAT_ADDR, 1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("stat_full", {24'd0, data_to_fc}, 32'h0000_0005);
    cycle(IO_ADDR, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < TX_DEPTH + 2; i++) begin
      cycle(UNMAPPED, 1'b0, 8'h00, 1'b1, 1'b1);
    end
    cycle(STAT_ADDR, 1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("stat_drained", {24'd0, data_to_fc}, 32'h0000_0006);

    // Unmapped accesses and stores to status must not disturb RAM or FIFO.
    cycle(UNMAPPED, 1'b1, 8'h77, 1'b0, 1'b1);
    cycle(STAT_ADDR, 1'b1, 8'h66, 1'b0, 1'b1);
    cycle(UNMAPPED, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(32'h0000_0000, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(32'h0000_1234, 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-queue, with a RAM store offered on the reset edge.
    for (int i = 0; i < 3; i++) begin
      cycle(IO_ADDR, 1'b1, 8'(8'h61 + i), 1'b0, 1'b1);
    end
    cycle(32'h0000_1234, 1'b1, 8'hEE, 1'b1, 1'b0);
    check_eq("rst_valid", {31'd0, io_valid_out}, 32'd0);
    cycle(32'h0000_1234, 1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("ram_kept", {24'd0, data_to_fc}, 32'h0000_00A5);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      cycle(pick_addr(), ($urandom_range(0, 1) == 1), 8'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/byte_ram_responder.md
BYTE_RAM_RESPONDER -- requirements
Module: byte_ram_responder

Interface
REQ-001 SHALL take parameter AddrWidth, default 17: byte-RAM address bits (128 KiB array).
REQ-002 SHALL take parameter IoAddr, default 32'h0003_0000: IO transmit-data byte address.
REQ-003 SHALL take parameter IoStatAddr, default 32'h0003_0004: IO status byte address.
REQ-004 SHALL take parameter FifoDepthLog, default 3: log2 of the transmit FIFO depth (8 entries).
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset; one clock, synchronous, active-low.
REQ-007 SHALL have port addr_from_fc, input, 32: byte address, sampled every cycle.
REQ-008 SHALL have port is_store_from_fc, input, 1: 1 = write data_from_fc to addr_from_fc this cycle; 0 = read.
REQ-009 SHALL have port data_from_fc, input, 8: store byte.
REQ-010 SHALL have port data_to_fc, output, 8: registered read byte.
REQ-011 SHALL have port io_full_to_fc, output, 1: transmit path cannot accept another byte.
REQ-012 SHALL have port io_byte_out, output, 8: byte at the FIFO head.
REQ-013 SHALL have port io_valid_out, output, 1: io_byte_out holds a valid byte.
REQ-014 SHALL have port io_ready_in, input, 1: downstream consumes the head byte when high with io_valid_out.
REQ-015 SHALL have port io_overflow_out, output, 1: sticky flag; a push was attempted while full.

Function
REQ-016 A cycle SHALL address RAM when addr_from_fc[31:AddrWidth] == 0.
REQ-017 It SHALL address IO when addr_from_fc equals IoAddr or IoStatAddr; any other address is unmapped.
REQ-018 A RAM store SHALL write mem[addr_from_fc[AddrWidth-1:0]] at the clock edge.
REQ-019 A RAM read SHALL present mem[addr] on data_to_fc exactly 1 cycle after the address is sampled.
REQ-020 data_to_fc SHALL also update on store cycles, returning the byte just written (write-first), so the byte-serial requester sees 1-cycle latency on every cycle.
REQ-021 A read of IoAddr SHALL return 8'h00 on the next cycle.
REQ-022 A read of IoStatAddr SHALL return {5'b0, io_overflow_out, FIFO empty, io_full_to_fc} on the next cycle.
REQ-023 Unmapped reads SHALL return 8'h00; unmapped stores and stores to IoStatAddr SHALL be ignored.
REQ-024 A store to IoAddr SHALL push data_from_fc into the FIFO tail when not full.
REQ-025 A store to IoAddr while full SHALL drop the byte and set io_overflow_out.
REQ-026 io_valid_out SHALL equal FIFO not-empty; io_byte_out SHALL equal the head entry.
REQ-027 A pop SHALL occur when io_valid_out && io_ready_in.
REQ-028 Push and pop in the same cycle SHALL both take effect and leave the count unchanged, including when full (the push is accepted because the pop frees the slot).
REQ-029 Read/write pointers SHALL be FifoDepthLog bits wide and wrap modulo the FIFO depth.
REQ-030 The count SHALL be FifoDepthLog+1 bits wide and range 0..depth.
REQ-031 io_full_to_fc SHALL be registered and equal (count == depth) after each edge.
REQ-032 The FIFO SHALL NOT push on a read cycle, on an unmapped cycle, or on a cycle that stores to any other address.

Reset
REQ-033 While rst == 0 at an edge, the block SHALL clear data_to_fc, pointers and count, io_full_to_fc and io_overflow_out to 0.
REQ-034 During that same edge the block SHALL perform no RAM write and no FIFO push/pop.
REQ-035 RAM contents and FIFO storage SHALL NOT be cleared by reset.
REQ-036 A reset asserted mid-drain SHALL discard all queued bytes; io_valid_out SHALL be 0 in the first cycle after reset.

Configuration
REQ-037 With macro IO_TX_FIFO_EN defined, the transmit path SHALL be the 2^FifoDepthLog-entry FIFO described above.
REQ-038 Without IO_TX_FIFO_EN, it SHALL be a single holding register: full = occupied.
REQ-039 Without IO_TX_FIFO_EN, push and pop in the same cycle SHALL replace the held byte; FifoDepthLog is ignored; all other behaviour is unchanged.

Verification
REQ-040 Store 8'hA5 to 32'h0000_1234, then read 32'h0000_1234 -> data_to_fc = 8'hA5 one cycle after the read address.
REQ-041 Store 8'h3C to 32'h0000_0010 -> data_to_fc = 8'h3C on the next cycle (write-first).
REQ-042 With io_ready_in = 0, store 8'h41..8'h48 to IoAddr -> io_full_to_fc = 1 after the 8th store.
REQ-043 Continue from REQ-042 with a 9th store of 8'h49 -> byte dropped, io_overflow_out = 1, IoStatAddr read = 8'h05.
REQ-044 Then raise io_ready_in -> io_byte_out sequence 8'h41..8'h48, one byte per cycle, then io_valid_out = 0 and the status read = 8'h06.
REQ-045 Read 32'h0004_0000 and store to it -> data_to_fc = 8'h00, RAM and FIFO unchanged.
REQ-046 Pull rst low with 3 bytes queued -> io_valid_out = 0, io_full_to_fc = 0, io_overflow_out = 0 the next cycle; earlier RAM data still readable.
